// File: rtl/vt52_pkg.sv
// ============================================================================
// Module   : vt52_pkg
// Purpose  : Shared constants, key offsets and FSM state type for the VT52
//            key encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vt52_pkg;

    localparam logic [7:0] ESC       = 8'h1B;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] FIN_UP    = 8'h41;
    localparam logic [7:0] FIN_DOWN  = 8'h42;
    localparam logic [7:0] FIN_RIGHT = 8'h43;
    localparam logic [7:0] FIN_LEFT  = 8'h44;
    localparam logic [7:0] FIN_PF1   = 8'h50;
    localparam logic [7:0] FIN_PF2   = 8'h51;
    localparam logic [7:0] FIN_PF3   = 8'h52;
    localparam logic [7:0] FIN_PF4   = 8'h53;
    localparam logic [7:0] ID_MID    = 8'h2F;

    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_RIGHT = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_PF1   = 3'd4;
    localparam logic [2:0] KEY_PF2   = 3'd5;
    localparam logic [2:0] KEY_PF3   = 3'd6;
    localparam logic [2:0] KEY_PF4   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2,
        SEND3 = 2'd3
    } state_t;

    typedef logic [1:0] len_t;

endpackage

`default_nettype wire

// File: rtl/vt52_key_encoder_if.sv
// ============================================================================
// Module   : vt52_key_encoder_if
// Purpose  : Key input, identify request and AXI-stream output of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vt52_key_encoder_if;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic       ident_req;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy;

    modport master (
        input  key_data, key_valid, ident_req, m_axis_tready,
        output key_ready, m_axis_tdata, m_axis_tvalid, busy
    );

    modport slave (
        output key_data, key_valid, ident_req, m_axis_tready,
        input  key_ready, m_axis_tdata, m_axis_tvalid, busy
    );
endinterface

`default_nettype wire

// File: rtl/vt52_key_map.sv
// ============================================================================
// Module   : vt52_key_map
// Purpose  : Combinational key code / identify -> byte sequence lookup.
//            Optional macro VT52_AUTO_LF_EN expands CR into CR LF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt52_key_map
    import vt52_pkg::*;
#(
    parameter logic [7:0] SPECIAL_BASE = 8'h80,
    parameter logic [7:0] IDENT_CHAR   = 8'h4B
) (
    input  logic [7:0] key_data,
    input  logic       ident_sel,
    output len_t       len,
    output logic [7:0] b1,
    output logic [7:0] b2,
    output logic [7:0] b3,
    output logic       drop
);

    logic [7:0] w_offset;
    assign w_offset = key_data - SPECIAL_BASE;

    always_comb begin
        len  = 2'd1;
        b1   = key_data;
        b2   = 8'h00;
        b3   = 8'h00;
        drop = 1'b0;
        if (ident_sel) begin
            len = 2'd3;
            b1  = ESC;
            b2  = ID_MID;
            b3  = IDENT_CHAR;
        end else if ((key_data >= SPECIAL_BASE) && (w_offset < 8'd8)) begin
            len = 2'd2;
            b1  = ESC;
            case (w_offset[2:0])
                KEY_UP:    b2 = FIN_UP;
                KEY_DOWN:  b2 = FIN_DOWN;
                KEY_RIGHT: b2 = FIN_RIGHT;
                KEY_LEFT:  b2 = FIN_LEFT;
                KEY_PF1:   b2 = FIN_PF1;
                KEY_PF2:   b2 = FIN_PF2;
                KEY_PF3:   b2 = FIN_PF3;
                KEY_PF4:   b2 = FIN_PF4;
                default:   b2 = 8'h00;
            endcase
`ifdef VT52_AUTO_LF_EN
        end else if (key_data == CR) begin
            len = 2'd2;
            b2  = LF;
`endif
        end else if (key_data[7]) begin
            // Unmapped high codes are consumed silently.
            drop = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vt52_key_encoder.sv
// ============================================================================
// Module   : vt52_key_encoder
// Purpose  : Encodes keys and identify requests into the VT52 host byte stream.
//            Optional macro VT52_AUTO_LF_EN (see vt52_key_map).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt52_key_encoder
    import vt52_pkg::*;
#(
    parameter logic [7:0] SPECIAL_BASE = 8'h80,
    parameter logic [7:0] IDENT_CHAR   = 8'h4B
) (
    input  logic                      clk,
    input  logic                      reset,
    vt52_key_encoder_if.master        bus
);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_tdata, w_tdata_nxt;
    logic       r_tvalid, w_tvalid_nxt;
    logic [7:0] r_b2, w_b2_nxt;
    logic [7:0] r_b3, w_b3_nxt;
    len_t       r_len, w_len_nxt;
    logic       r_pend, w_pend_nxt;

    logic       w_key_ready, w_take, w_hs;
    len_t       w_map_len;
    logic [7:0] w_map_b1, w_map_b2, w_map_b3;
    logic       w_map_drop;

    assign w_key_ready = (r_state == IDLE) && !r_pend;
    assign w_take      = bus.key_valid && w_key_ready;
    assign w_hs        = r_tvalid && bus.m_axis_tready;

    // A pending identify steers the map away from the key input.
    vt52_key_map #(
        .SPECIAL_BASE (SPECIAL_BASE),
        .IDENT_CHAR   (IDENT_CHAR)
    ) u_map (
        .key_data  (bus.key_data),
        .ident_sel (r_pend),
        .len       (w_map_len),
        .b1        (w_map_b1),
        .b2        (w_map_b2),
        .b3        (w_map_b3),
        .drop      (w_map_drop)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tdata_nxt  = r_tdata;
        w_tvalid_nxt = r_tvalid;
        w_b2_nxt     = r_b2;
        w_b3_nxt     = r_b3;
        w_len_nxt    = r_len;
        w_pend_nxt   = r_pend | bus.ident_req;
        case (r_state)
            IDLE: begin
                if ((r_pend || w_take) && !w_map_drop) begin
                    w_state_nxt  = SEND1;
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = w_map_b1;
                    w_b2_nxt     = w_map_b2;
                    w_b3_nxt     = w_map_b3;
                    w_len_nxt    = w_map_len;
                    if (r_pend) begin
                        w_pend_nxt = 1'b0;
                    end
                end
            end
            SEND1: begin
                if (w_hs) begin
                    if (r_len > 2'd1) begin
                        w_state_nxt = SEND2;
                        w_tdata_nxt = r_b2;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_tvalid_nxt = 1'b0;
                    end
                end
            end
            SEND2: begin
                if (w_hs) begin
                    if (r_len > 2'd2) begin
                        w_state_nxt = SEND3;
                        w_tdata_nxt = r_b3;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_tvalid_nxt = 1'b0;
                    end
                end
            end
            SEND3: begin
                if (w_hs) begin
                    w_state_nxt  = IDLE;
                    w_tvalid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_tvalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_tdata  <= 8'h00;
            r_tvalid <= 1'b0;
            r_b2     <= 8'h00;
            r_b3     <= 8'h00;
            r_len    <= 2'd1;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tdata  <= w_tdata_nxt;
            r_tvalid <= w_tvalid_nxt;
            r_b2     <= w_b2_nxt;
            r_b3     <= w_b3_nxt;
            r_len    <= w_len_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    assign bus.key_ready     = w_key_ready;
    assign bus.m_axis_tdata  = r_tdata;
    assign bus.m_axis_tvalid = r_tvalid;
    assign bus.busy          = (r_state != IDLE) || r_pend;

endmodule

`default_nettype wire

// File: tb/tb_vt52_key_encoder.sv
// ============================================================================
// Module   : tb_vt52_key_encoder
// Purpose  : Directed and random stimulus for vt52_key_encoder, checked
//            against a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vt52_key_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vt52_key_encoder_if bus_if();

    vt52_key_encoder #(
        .SPECIAL_BASE (8'h80),
        .IDENT_CHAR   (8'h4B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    string      cur_test = "init";

    // Model: bytes still owed for the sequence on the wire, front is presented.
    logic [7:0] q_cur[$];
    logic       m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s.%s got=%0h expected=%0h at %0t", cur_test, tag, got, exp, $time);
        end
    endtask

    function automatic void load_key(input logic [7:0] k);
        int         idx;
        logic       is_cr;
        logic [7:0] fin;
        idx   = int'(k) - 128;
        is_cr = 1'b0;
`ifdef VT52_AUTO_LF_EN
        is_cr = (k == 8'h0D);
`endif
        if (k < 8'h80) begin
            q_cur.push_back(k);
            if (is_cr) q_cur.push_back(8'h0A);
        end else if (idx < 8) begin
            fin = (idx < 4) ? 8'h41 + 8'(idx) : 8'h50 + 8'(idx - 4);
            q_cur.push_back(8'h1B);
            q_cur.push_back(fin);
        end
    endfunction

    task automatic check_outputs();
        logic busy_q;
        busy_q = (q_cur.size() > 0);
        check("tvalid", 32'(bus_if.m_axis_tvalid), 32'(busy_q));
        if (busy_q) check("tdata", 32'(bus_if.m_axis_tdata), 32'(q_cur[0]));
        check("key_ready", 32'(bus_if.key_ready), 32'(!busy_q && !m_pend));
        check("busy", 32'(bus_if.busy), 32'(busy_q || m_pend));
    endtask

    task automatic step(input logic rst, input logic kv, input logic [7:0] kd,
                        input logic ir, input logic tr);
        reset                = rst;
        bus_if.key_valid     = kv;
        bus_if.key_data      = kd;
        bus_if.ident_req     = ir;
        bus_if.m_axis_tready = tr;
        @(posedge clk);
        if (rst) begin
            q_cur.delete();
            m_pend = 1'b0;
        end else if (q_cur.size() > 0) begin
            if (tr) void'(q_cur.pop_front());
            m_pend = m_pend | ir;
        end else if (m_pend) begin
            q_cur  = '{8'h1B, 8'h2F, 8'h4B};
            m_pend = 1'b0;
        end else begin
            if (kv) load_key(kd);
            m_pend = ir;
        end
        #1;
        check_outputs();
        if (rst) check("rst_tdata", 32'(bus_if.m_axis_tdata), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic       r_rst, r_kv, r_ir, r_tr;
        logic [7:0] r_kd;

        cur_test = "reset";
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        cur_test = "ascii";
        step(1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
        idle(3);

        cur_test = "special_stall";
        step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(4);

        cur_test = "ident_merge";
        step(1'b0, 1'b1, 8'h82, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(8);

        cur_test = "ident_vs_key";
        step(1'b0, 1'b1, 8'h41, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h31, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
        idle(3);

        cur_test = "ident_with_accept";
        step(1'b0, 1'b1, 8'h41, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h32, 1'b0, 1'b1);
        idle(4);

        cur_test = "drop";
        step(1'b0, 1'b1, 8'hC5, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h31, 1'b0, 1'b1);
        idle(3);

        cur_test = "cr";
        step(1'b0, 1'b1, 8'h0D, 1'b0, 1'b1);
        idle(4);

        cur_test = "reset_mid";
        step(1'b0, 1'b1, 8'h84, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(4);

        cur_test = "random";
        for (int n = 0; n < 4000; n++) begin
            r_rst = ($urandom_range(0, 399) == 0);
            r_kv  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       r_kd = 8'h80 + 8'($urandom_range(0, 7));
                1:       r_kd = 8'($urandom_range(128, 255));
                2:       r_kd = 8'h0D;
                default: r_kd = 8'($urandom_range(0, 127));
            endcase
            r_ir = ($urandom_range(0, 15) == 0);
            r_tr = ($urandom_range(0, 3) != 0);
            step(r_rst, r_kv, r_kd, r_ir, r_tr);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
